baccarat_engine: RTL and testbench

- Top-level Baccarat engine for the FPGA board. It deals player and dealer cards, one per press of a step pushbutton, from a free-running pseudo-random card counter.
- It applies the standard Baccarat third-card rules, shows the cards on six 7-segment displays, and shows the scores and winner on LEDs.
- One clock domain (CLOCK_50); the step button is a synchronized input, not a clock.

---
 rtl/baccarat_engine.sv | 136 +++++++++++++
 tb/tb_baccarat_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_engine.sv
// baccarat_engine: step-driven Baccarat dealer with third-card rules,
// 7-segment card display and score/winner LEDs.
module baccarat_engine (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    typedef enum logic [2:0] {
        DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DECIDE, DEAL_D3_CHK, DONE
    } state_t;

    state_t     r_state, w_next;
    logic       w_rst_n, w_step, w_draw, w_unused;
    logic       r_sync1, r_sync2, r_prev;
    logic [3:0] r_cnt, r_pc1, r_pc2, r_pc3, r_dc1, r_dc2, r_dc3;
    logic [3:0] w_ps, w_ds, w_p3v;
    logic [1:0] w_win;
    logic [5:0] w_ld;

    function automatic logic [3:0] card_val(input logic [3:0] c);
        return (c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
        s = (s >= 5'd20) ? s - 5'd20 : (s >= 5'd10) ? s - 5'd10 : s;
        return s[3:0];
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b0001000;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b1000000;
            4'd11:   return 7'b1100001;
            4'd12:   return 7'b0011000;
            4'd13:   return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_rst_n  = KEY[3];
    assign w_unused = ^{KEY[2], KEY[0]};
    assign w_step   = r_sync2 & ~r_prev;
    assign w_ps     = score(r_pc1, r_pc2, r_pc3);
    assign w_ds     = score(r_dc1, r_dc2, r_dc3);
    assign w_p3v    = card_val(r_pc3);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= DEAL_P1;
            r_cnt   <= 4'd1;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pc1   <= 4'd0;
            r_pc2   <= 4'd0;
            r_pc3   <= 4'd0;
            r_dc1   <= 4'd0;
            r_dc2   <= 4'd0;
            r_dc3   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_cnt == 4'd13) ? 4'd1 : r_cnt + 4'd1;
            r_sync1 <= KEY[1];
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_ld[0]) r_pc1 <= r_cnt;
            if (w_ld[1]) r_pc2 <= r_cnt;
            if (w_ld[2]) r_pc3 <= r_cnt;
            if (w_ld[3]) r_dc1 <= r_cnt;
            if (w_ld[4]) r_dc2 <= r_cnt;
            if (w_ld[5]) r_dc3 <= r_cnt;
        end
    end

    // Dealer third-card table, only consulted after the player has drawn.
    always_comb begin
        w_draw = (w_ds <= 4'd2)
               | ((w_ds == 4'd3) & (w_p3v != 4'd8))
               | ((w_ds == 4'd4) & (w_p3v >= 4'd2) & (w_p3v <= 4'd7))
               | ((w_ds == 4'd5) & (w_p3v >= 4'd4) & (w_p3v <= 4'd7))
               | ((w_ds == 4'd6) & ((w_p3v == 4'd6) | (w_p3v == 4'd7)));
    end

    always_comb begin
        w_next = r_state;
        w_ld   = 6'b000000;
        if (w_step) begin
            case (r_state)
                DEAL_P1: begin w_ld[0] = 1'b1; w_next = DEAL_D1; end
                DEAL_D1: begin w_ld[3] = 1'b1; w_next = DEAL_P2; end
                DEAL_P2: begin w_ld[1] = 1'b1; w_next = DEAL_D2; end
                DEAL_D2: begin w_ld[4] = 1'b1; w_next = DECIDE;  end
                DECIDE: begin
                    if (w_ps >= 4'd8 || w_ds >= 4'd8) begin
                        w_next = DONE;
                    end else if (w_ps <= 4'd5) begin
                        w_ld[2] = 1'b1;
                        w_next  = DEAL_D3_CHK;
                    end else begin
                        w_ld[5] = (w_ds <= 4'd5);
                        w_next  = DONE;
                    end
                end
                DEAL_D3_CHK: begin w_ld[5] = w_draw; w_next = DONE; end
                default: ;
            endcase
        end
    end

    assign w_win = (r_state != DONE) ? 2'b00 :
                   (w_ps > w_ds) ? 2'b01 : (w_ds > w_ps) ? 2'b10 : 2'b11;
    assign LEDR  = {w_win, w_ds, w_ps};
    assign HEX0  = seg(r_pc1);
    assign HEX1  = seg(r_pc2);
    assign HEX2  = seg(r_pc3);
    assign HEX3  = seg(r_dc1);
    assign HEX4  = seg(r_dc2);
    assign HEX5  = seg(r_dc3);
endmodule

// File: tb/tb_baccarat_engine.sv
// tb_baccarat_engine: random and directed Baccarat games checked against a
// rule-level game model through a cycle-stamped scoreboard.
module tb_baccarat_engine;
    logic       clk = 1'b0;
    logic [3:0] key = 4'b0000;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rel = 0;
    logic [3:0] m_cnt;

    typedef struct {
        int         at;
        logic [9:0] ledr;
        logic [41:0] hex;
        string      name;
    } exp_t;
    exp_t q[$];

    int pc[3];
    int dc[3];
    int phase;

    logic [6:0] seg_t [16] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                               7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};

    baccarat_engine dut (
        .CLOCK_50(clk), .KEY(key), .LEDR(ledr),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2),
        .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles since reset release give the free-running card counter value.
    always @(posedge clk or negedge key[3])
        if (!key[3]) rel <= 0;
        else rel <= rel + 1;
    assign m_cnt = 4'(1 + (rel % 13));

    function automatic int cv(input int c);
        return (c <= 9) ? c : 0;
    endfunction

    function automatic int sc(input int c[3]);
        return (cv(c[0]) + cv(c[1]) + cv(c[2])) % 10;
    endfunction

    task automatic model_clear();
        pc = '{0, 0, 0};
        dc = '{0, 0, 0};
        phase = 0;
    endtask

    task automatic model_step(input int r);
        int ps, ds, p3;
        bit draw;
        ps = sc(pc);
        ds = sc(dc);
        case (phase)
            0: begin pc[0] = r; phase = 1; end
            1: begin dc[0] = r; phase = 2; end
            2: begin pc[1] = r; phase = 3; end
            3: begin dc[1] = r; phase = 4; end
            4: begin
                if (ps >= 8 || ds >= 8) phase = 6;
                else if (ps <= 5) begin pc[2] = r; phase = 5; end
                else begin
                    if (ds <= 5) dc[2] = r;
                    phase = 6;
                end
            end
            5: begin
                p3 = cv(pc[2]);
                case (ds)
                    0, 1, 2: draw = 1;
                    3:       draw = (p3 != 8);
                    4:       draw = (p3 >= 2 && p3 <= 7);
                    5:       draw = (p3 >= 4 && p3 <= 7);
                    6:       draw = (p3 == 6 || p3 == 7);
                    default: draw = 0;
                endcase
                if (draw) dc[2] = r;
                phase = 6;
            end
            default: ;
        endcase
    endtask

    task automatic push_exp(input string name, input int at);
        exp_t e;
        int ps, ds;
        logic [1:0] w;
        ps = sc(pc);
        ds = sc(dc);
        w = (phase != 6) ? 2'b00 : (ps > ds) ? 2'b01 : (ds > ps) ? 2'b10 : 2'b11;
        e.at   = at;
        e.name = name;
        e.ledr = {w, 4'(ds), 4'(ps)};
        e.hex  = {seg_t[dc[2]], seg_t[dc[1]], seg_t[dc[0]],
                  seg_t[pc[2]], seg_t[pc[1]], seg_t[pc[0]]};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            checks++;
            if (ledr !== e.ledr) begin
                errors++;
                $display("FAIL %s LEDR at cycle %0d: got %b expected %b", e.name, cyc, ledr, e.ledr);
            end
            checks++;
            if ({hex5, hex4, hex3, hex2, hex1, hex0} !== e.hex) begin
                errors++;
                $display("FAIL %s HEX5..0 at cycle %0d: got %h expected %h", e.name, cyc,
                         {hex5, hex4, hex3, hex2, hex1, hex0}, e.hex);
            end
        end
    end

    task automatic do_reset(input int low_ns, input bit poke);
        @(negedge clk);
        key[3] = 1'b0;
        model_clear();
        if (low_ns >= 20) push_exp("in_reset", cyc + 1);
        if (poke) begin
            key[1] = 1'b1;
            #12 key[1] = 1'b0;
        end
        #(low_ns) key[3] = 1'b1;
        push_exp("after_reset", cyc + 1);
        repeat (3) @(negedge clk);
    endtask

    // Raise KEY[1] when the counter is two cycles short of rank r so that
    // rank r is what the engine captures on the resulting step pulse.
    task automatic step(input int r, input int hold);
        int n;
        logic [3:0] tgt;
        tgt = 4'(((r + 10) % 13) + 1);
        n = 0;
        @(negedge clk);
        while (m_cnt != tgt && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL step_align rank %0d: counter %0d never reached %0d", r, m_cnt, tgt);
        end
        key[1] = 1'b1;
        model_step(r);
        push_exp("step", cyc + 3);
        repeat (hold) @(negedge clk);
        key[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic game(input int r[7]);
        do_reset(20, 1'b0);
        for (int i = 0; i < 7; i++) step(r[i], 4);
    endtask

    function automatic int rr();
        return int'($urandom_range(1, 13));
    endfunction

    initial begin
        int n;
        do_reset(20, 1'b1);
        step(rr(), 4);
        step(rr(), 4);
        do_reset(20, 1'b1);
        step(rr(), 40);
        step(rr(), 4);
        do_reset(3, 1'b0);
        step(rr(), 4);
        game('{4, rr(), 5, rr(), rr(), rr(), rr()});
        game('{4, 9, 5, 10, rr(), rr(), rr()});
        game('{1, 2, 2, 4, 7, rr(), rr()});
        game('{1, 2, 2, 4, 8, rr(), rr()});
        game('{13, 10, 12, 11, rr(), rr(), rr()});
        game('{3, 3, 3, 3, rr(), rr(), rr()});
        for (int g = 0; g < 30; g++)
            game('{rr(), rr(), rr(), rr(), rr(), rr(), rr()});
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks += q.size();
            errors += q.size();
            $display("FAIL scoreboard_drain: %0d expectations left unchecked", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
